// File: rtl/pipe_pkg.sv
// Shared constants and types for the parametrised pipeline register chain.
package pipe_pkg;

  localparam int NSTAGE_MIN = 2;
  localparam int NSTAGE_MAX = 8;

  // Width needed to count 0..n valid stages.
  function automatic int occW(input int n);
    return $clog2(n + 1);
  endfunction

  // Default payload bundle of the 5-stage core.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
  } corePayload_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid + payload with flush > hold > bubble > advance priority.
module pipe_stage_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             upHold,
  input  logic             upValid,
  input  logic [WIDTH-1:0] upData,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             nxtValid
);

  logic [WIDTH-1:0] nxtData;

  // A bubble or flush only clears valid; leaving data alone saves the payload enables.
  always_comb begin
    nxtValid = valid;
    nxtData  = data;
    if (flush)       nxtValid = 1'b0;
    else if (hold)   nxtValid = valid;
    else if (upHold) nxtValid = 1'b0;
    else begin
      nxtValid = upValid;
      nxtData  = upData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= nxtValid;
      data  <= nxtData;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// NSTAGE-deep pipeline register chain with stall backpressure, flush and bubble insertion.
// Define PIPE_PERF_CNT_EN to add stall/bubble/flush performance counters.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int WIDTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [NSTAGE-1:0]         stall,
  input  logic [NSTAGE-1:0]         flush,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [NSTAGE-1:0]         stage_valid,
  output logic [occW(NSTAGE)-1:0]   occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          bubble_cycles,
  output logic [CNT_W-1:0]          flush_events
`endif
);

  localparam int OCC_W = occW(NSTAGE);

  if (NSTAGE < NSTAGE_MIN || NSTAGE > NSTAGE_MAX || CNT_W < 1) begin : gBadParam
    $error("pipe_ctrl_chain: parameter out of range");
  end

  logic [NSTAGE-1:0]            hold;
  logic [NSTAGE-1:0]            nxtValid;
  logic [NSTAGE-1:0][WIDTH-1:0] stageData;
  logic [OCC_W-1:0]             occNxt;

  // A stall freezes its own stage and everything upstream of it.
  always_comb begin
    logic acc;
    hold = '0;
    acc  = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      acc     = acc | stall[k];
      hold[k] = acc;
    end
  end

  assign in_ready  = reset | ~hold[0];
  assign out_valid = stage_valid[NSTAGE-1];
  assign out_data  = stageData[NSTAGE-1];

  for (genvar k = 0; k < NSTAGE; k++) begin : gStage
    logic             upHold;
    logic             upValid;
    logic [WIDTH-1:0] upData;
    if (k == 0) begin : gHead
      assign upHold  = 1'b0;
      assign upValid = in_valid;
      assign upData  = in_data;
    end else begin : gBody
      assign upHold  = hold[k-1];
      assign upValid = stage_valid[k-1];
      assign upData  = stageData[k-1];
    end

    pipe_stage_reg #(.WIDTH(WIDTH)) uReg (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush[k]),
      .hold     (hold[k]),
      .upHold   (upHold),
      .upValid  (upValid),
      .upData   (upData),
      .valid    (stage_valid[k]),
      .data     (stageData[k]),
      .nxtValid (nxtValid[k])
    );
  end

  // Occupancy is the popcount of the valid vector being loaded on this edge.
  always_comb begin
    occNxt = '0;
    for (int k = 0; k < NSTAGE; k++) occNxt = occNxt + OCC_W'(nxtValid[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) occupancy <= '0;
    else       occupancy <= occNxt;
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
      flush_events  <= '0;
    end else begin
      if (|stall)     stall_cycles  <= stall_cycles + CNT_W'(1);
      if (!out_valid) bubble_cycles <= bubble_cycles + CNT_W'(1);
      if (|flush)     flush_events  <= flush_events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed, table-driven check of pipe_ctrl_chain with NSTAGE=4 (counters checked when PIPE_PERF_CNT_EN is set).
module tb_pipe_ctrl_chain;

  localparam int NSTAGE = 4;
  localparam int WIDTH  = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [NSTAGE-1:0] stage_valid;
  logic [2:0]        occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cycles, bubble_cycles, flush_events;
`endif

  pipe_ctrl_chain #(.NSTAGE(NSTAGE), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles),
    .flush_events  (flush_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [NSTAGE-1:0] st;
    logic [NSTAGE-1:0] fl;
    logic              iv;
    logic [WIDTH-1:0]  id;
    logic              eReady;
    logic              eOutV;
    logic [WIDTH-1:0]  eOutD;
    logic [NSTAGE-1:0] eSv;
    logic [2:0]        eOcc;
  } vec_t;

  vec_t vq[$];
  int   nTests = 0;
  int   nFail  = 0;

  function automatic vec_t mk(logic rst, logic [3:0] st, logic [3:0] fl, logic iv, logic [15:0] id,
                              logic er, logic ev, logic [15:0] ed, logic [3:0] esv, logic [2:0] eocc);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.iv = iv; v.id = id;
    v.eReady = er; v.eOutV = ev; v.eOutD = ed; v.eSv = esv; v.eOcc = eocc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst out_valid",   32'(out_valid),   32'd0);
    chk("rst out_data",    32'(out_data),    32'd0);
    chk("rst stage_valid", 32'(stage_valid), 32'd0);
    chk("rst occupancy",   32'(occupancy),   32'd0);
    chk("rst in_ready",    32'(in_ready),    32'd1);

    //              rst st       fl       iv id   rdy ov od  sv       occ
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1,   1,  0, 0,  4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 2,   1,  0, 0,  4'b0011, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 3,   1,  0, 0,  4'b0111, 3));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 4,   1,  1, 1,  4'b1111, 4));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 5,   1,  1, 2,  4'b1111, 4));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 1, 6,   0,  0, 2,  4'b0111, 3));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 1, 6,   0,  0, 2,  4'b0111, 3));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 6,   1,  1, 3,  4'b1111, 4));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 7,   1,  1, 4,  4'b1111, 4));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 8,   1,  1, 5,  4'b1111, 4));
    vq.push_back(mk(0, 4'b0000, 4'b0011, 0, 0,   1,  1, 6,  4'b1100, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 9,   1,  1, 7,  4'b1001, 2));
    vq.push_back(mk(0, 4'b0010, 4'b0010, 1, 10,  0,  0, 7,  4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 10,  1,  0, 7,  4'b0011, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 11,  1,  0, 8,  4'b0111, 3));
    vq.push_back(mk(1, 4'b0000, 4'b0000, 1, 12,  1,  0, 0,  4'b0000, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 12,  1,  0, 0,  4'b0001, 1));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 13,  1,  0, 0,  4'b0011, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 14,  1,  0, 0,  4'b0111, 3));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 15,  1,  1, 12, 4'b1111, 4));
    vq.push_back(mk(0, 4'b1000, 4'b0000, 1, 16,  0,  1, 12, 4'b1111, 4));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 16,  1,  1, 13, 4'b1111, 4));

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; stall = vq[i].st; flush = vq[i].fl;
      in_valid = vq[i].iv; in_data = vq[i].id;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].eReady));
      step();
      chk($sformatf("v%0d out_valid", i),   32'(out_valid),   32'(vq[i].eOutV));
      chk($sformatf("v%0d out_data", i),    32'(out_data),    32'(vq[i].eOutD));
      chk($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vq[i].eSv));
      chk($sformatf("v%0d occupancy", i),   32'(occupancy),   32'(vq[i].eOcc));
    end

    // Single payload latency through an idle pipe.
    reset = 1'b1; stall = '0; flush = '0; in_valid = 1'b0;
    step();
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h00AB;
    step();
    in_valid = 1'b0; in_data = '0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency cycles", 32'(n), 32'd4);
    chk("latency data",   32'(out_data), 32'h00AB);

`ifdef PIPE_PERF_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("cnt rst stall",  stall_cycles,  32'd0);
    chk("cnt rst bubble", bubble_cycles, 32'd0);
    chk("cnt rst flush",  flush_events,  32'd0);
    // 3 stall cycles at start, 2 flush cycles at end; out_valid is low in 8 of the 10 cycles.
    for (int i = 0; i < 10; i++) begin
      stall    = (i < 3)  ? 4'b0001 : 4'b0000;
      flush    = (i >= 8) ? 4'b1000 : 4'b0000;
      in_valid = 1'b1;
      in_data  = 16'(100 + i);
      step();
    end
    stall = '0; flush = '0; in_valid = 1'b0;
    chk("cnt stall_cycles",  stall_cycles,  32'd3);
    chk("cnt flush_events",  flush_events,  32'd2);
    chk("cnt bubble_cycles", bubble_cycles, 32'd8);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
- Parametrised chain of NSTAGE pipeline registers with per-stage valid, stall and flush.
- Generalises the fixed F/D, D/E, E/M and M/W registers of the core into one reusable block.
- Stall backpressure and bubble insertion are handled internally, driven by the hazard unit's stall/flush vectors.
- Sits between pipeline stage logic; payload is an opaque WIDTH-bit bundle (instr, pc, control, operands).

Parameters:
NSTAGE, 4, number of register stages (min 2, max 8); stage 0 is nearest the fetch side
WIDTH, 64, payload bits per stage
CNT_W, 32, width of the optional performance counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  payload at in_data is a real instruction
in_data  input  WIDTH  payload entering stage 0
in_ready  output  1  stage 0 will capture this cycle (= !hold[0]), combinational
stall  input  NSTAGE  stall[k]: stage k must hold its contents
flush  input  NSTAGE  flush[k]: stage k becomes a bubble
out_valid  output  1  valid of stage NSTAGE-1
out_data  output  WIDTH  payload of stage NSTAGE-1
stage_valid  output  NSTAGE  valid bit of every stage (for hazard/forwarding qualification)
occupancy  output  $clog2(NSTAGE+1)  registered count of valid stages
stall_cycles  output  CNT_W  only with PIPE_PERF_CNT_EN
bubble_cycles  output  CNT_W  only with PIPE_PERF_CNT_EN
flush_events  output  CNT_W  only with PIPE_PERF_CNT_EN

Behaviour:
- hold[k] = OR of stall[j] for j >= k: a stall freezes its own stage and every upstream stage.
- Per stage k, at each rising edge, first matching rule applies:
  - reset: valid <= 0, data <= 0.
  - flush[k]: valid <= 0, data unchanged. Flush beats hold.
  - hold[k]: valid and data unchanged.
  - k = 0: valid <= in_valid, data <= in_data.
  - hold[k-1] (upstream frozen, k not): bubble; valid <= 0, data unchanged.
  - otherwise: valid <= valid[k-1], data <= data[k-1].
- Latency with no stall or flush: exactly NSTAGE cycles from in_data to out_data.
- Throughput: 1 payload per cycle.
- in_valid = 0 while in_ready = 1 inserts a bubble at stage 0.
- A payload presented while in_ready = 0 is not captured; the source must re-present it.
- occupancy equals the popcount of the next-state valid vector, registered on the same edge. Reset value 0.
- stall[NSTAGE-1] acts as downstream backpressure: out_valid and out_data are held.
- Simultaneous stall[k] and flush[k]:
  - stage k clears.
  - Upstream stages still hold, because hold is derived from stall only.
  - stage k+1 receives a bubble.
- Flush of an upstream stage does not disturb downstream stages.
- Any flush/stall combination is legal in any cycle; there is no illegal input state.
- Reset asserted mid-stream discards all contents in one cycle; in_ready = 1 during reset.
- Outputs after reset: out_valid = 0, out_data = 0, stage_valid = 0, occupancy = 0, counters = 0.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, three CNT_W-bit wrapping counters, cleared by reset:
  - stall_cycles: +1 each cycle with |stall.
  - bubble_cycles: +1 each cycle with out_valid = 0.
  - flush_events: +1 each cycle with |flush.
- When undefined: counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - NSTAGE_MIN / NSTAGE_MAX constants.
  - occupancy width function.
  - Default payload struct typedef for the 5-stage core.
- Sub-module pipe_stage_reg:
  - one stage register with valid, the hold/flush/bubble priority mux and synchronous reset.
  - instantiated NSTAGE times by a generate loop.
- Top level computes hold[] and occupancy, and holds the optional counters.

Test Plan:
- Reset, then stream in_data = 1,2,3,... with in_valid = 1, NSTAGE = 4 -> out_data = 1 on cycle 4 after first capture; then one value per cycle; occupancy reaches 4.
- stall[2] = 1 for 2 cycles with full pipe -> stages 0-2 frozen; in_ready = 0; stage 3 receives 2 bubbles; out_valid = 0 for 2 cycles; then the stream resumes with no data lost or duplicated.
- flush = 4'b0011 in one cycle with pipe holding 5,6,7,8 (stage3 = 5) -> 5 and 6 exit normally; stages 0-1 become bubbles; occupancy drops from 4 to 2.
- stall[1] = 1 and flush[1] = 1 together -> stage 1 cleared; stage 0 holds; stage 2 gets a bubble; in_ready = 0.
- Assert reset mid-stream with occupancy = 3 -> next cycle stage_valid = 0, out_valid = 0, occupancy = 0, in_ready = 1.
- With PIPE_PERF_CNT_EN: 10 cycles containing 3 stall cycles and 2 flush cycles after reset -> stall_cycles = 3, flush_events = 2; bubble_cycles equals the count of out_valid = 0 cycles.
